// File: rtl/srio_dma_scheduler.sv
// srio_dma_scheduler: splits one DMA job into SWRITE packets for the SRIO initiator,
// optionally follows with a completion doorbell, and reports busy/done/error.
`default_nettype none

module srio_dma_scheduler #(
  parameter int MAX_PKT_BYTES = 256,
  parameter int DB_TIMEOUT    = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        dma_start,
  input  logic        dma_abort,
  input  logic [31:0] dma_src_addr,
  input  logic [33:0] dma_dest_addr,
  input  logic [23:0] dma_total_bytes,
  input  logic [7:0]  dma_dest_id,
  input  logic        dma_db_en,
  input  logic [15:0] dma_db_info,
  output logic [7:0]  ucfg_dest_id,
  output logic [31:0] ucfg_src_start_addr,
  output logic [33:0] ucfg_dest_start_addr,
  output logic [8:0]  ucfg_byte_count,
  output logic [15:0] ucfg_db_info,
  output logic        ucfg_wr_n,
  output logic        ucfg_normal_trigger,
  output logic        ucfg_db_trigger,
  input  logic        srio_initial_busy,
  input  logic        srio_db_resp,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_err,
  output logic [1:0]  dma_err_code
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PKT_ISSUE = 3'd1,
    S_PKT_ACK   = 3'd2,
    S_PKT_WAIT  = 3'd3,
    S_DB_ISSUE  = 3'd4,
    S_DB_ACK    = 3'd5,
    S_DB_WAIT   = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  localparam logic [23:0] MAX_BYTES = 24'(MAX_PKT_BYTES);
  localparam logic [15:0] TMO_LIMIT = 16'(DB_TIMEOUT);

  state_e      state_q;
  logic [31:0] src_q;
  logic [33:0] dest_q;
  logic [23:0] rem_q;
  logic [7:0]  dest_id_q;
  logic        db_en_q;
  logic [15:0] db_info_q;
  logic [15:0] tmo_q;

  logic [8:0]  chunk;
  logic [31:0] src_d;
  logic [33:0] dest_d;
  logic [23:0] rem_d;

  // Current packet length is derived straight from the remaining count so it is
  // stable for the whole PKT_ISSUE state, ahead of the trigger.
  assign chunk  = (rem_q > MAX_BYTES) ? MAX_BYTES[8:0] : rem_q[8:0];
  assign src_d  = src_q + {23'd0, chunk};
  assign dest_d = dest_q + {25'd0, chunk};
  assign rem_d  = rem_q - {15'd0, chunk};

  assign ucfg_byte_count      = chunk;
  assign ucfg_src_start_addr  = src_q;
  assign ucfg_dest_start_addr = dest_q;
  assign ucfg_dest_id         = dest_id_q;
  assign ucfg_db_info         = db_info_q;
  assign ucfg_wr_n            = 1'b0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q             <= S_IDLE;
      src_q               <= '0;
      dest_q              <= '0;
      rem_q               <= '0;
      dest_id_q           <= '0;
      db_en_q             <= 1'b0;
      db_info_q           <= '0;
      tmo_q               <= '0;
      ucfg_normal_trigger <= 1'b0;
      ucfg_db_trigger     <= 1'b0;
      dma_busy            <= 1'b0;
      dma_done            <= 1'b0;
      dma_err             <= 1'b0;
      dma_err_code        <= 2'd0;
    end else begin
      ucfg_normal_trigger <= 1'b0;
      ucfg_db_trigger     <= 1'b0;
      dma_done            <= 1'b0;
      dma_err             <= 1'b0;
      dma_err_code        <= 2'd0;
      case (state_q)
        S_IDLE: begin
          if (dma_start) begin
            if ((dma_src_addr[2:0] != 3'd0) || (dma_dest_addr[2:0] != 3'd0) ||
                (dma_total_bytes == 24'd0)) begin
              dma_err      <= 1'b1;
              dma_err_code <= 2'd1;
            end else begin
              src_q     <= dma_src_addr;
              dest_q    <= dma_dest_addr;
              rem_q     <= dma_total_bytes;
              dest_id_q <= dma_dest_id;
              db_en_q   <= dma_db_en;
              db_info_q <= dma_db_info;
              dma_busy  <= 1'b1;
              state_q   <= S_PKT_ISSUE;
            end
          end
        end
        S_PKT_ISSUE: begin
          if (!srio_initial_busy) begin
            ucfg_normal_trigger <= 1'b1;
            state_q             <= S_PKT_ACK;
          end
        end
        S_PKT_ACK: state_q <= S_PKT_WAIT;
        S_PKT_WAIT: begin
          if (!srio_initial_busy) begin
            src_q  <= src_d;
            dest_q <= dest_d;
            rem_q  <= rem_d;
            if (rem_d == 24'd0) begin
              if (db_en_q) begin
                state_q <= S_DB_ISSUE;
              end else begin
                dma_done <= 1'b1;
                state_q  <= S_DONE;
              end
            end else if (dma_abort) begin
              dma_done     <= 1'b1;
              dma_err      <= 1'b1;
              dma_err_code <= 2'd2;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_PKT_ISSUE;
            end
          end
        end
        S_DB_ISSUE: begin
          if (!srio_initial_busy) begin
            ucfg_db_trigger <= 1'b1;
            tmo_q           <= '0;
            state_q         <= S_DB_ACK;
          end
        end
        S_DB_ACK: begin
          if (srio_db_resp) begin
            dma_done <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            tmo_q   <= tmo_q + 16'd1;
            state_q <= S_DB_WAIT;
          end
        end
        S_DB_WAIT: begin
          if (srio_db_resp) begin
            dma_done <= 1'b1;
            state_q  <= S_DONE;
          end else if (tmo_q == TMO_LIMIT) begin
            dma_done     <= 1'b1;
            dma_err      <= 1'b1;
            dma_err_code <= 2'd3;
            state_q      <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_DONE: begin
          dma_busy <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_srio_dma_scheduler.sv
// Directed bench for srio_dma_scheduler with a small reactive initiator model.
`default_nettype none

module tb_srio_dma_scheduler;

  localparam int TMO = 200;
  localparam int BL  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_start = 1'b0, dma_abort = 1'b0, dma_db_en = 1'b0;
  logic [31:0] dma_src_addr = '0;
  logic [33:0] dma_dest_addr = '0;
  logic [23:0] dma_total_bytes = '0;
  logic [7:0]  dma_dest_id = 8'h5A;
  logic [15:0] dma_db_info = 16'hBEEF;
  logic [7:0]  ucfg_dest_id;
  logic [31:0] ucfg_src_start_addr;
  logic [33:0] ucfg_dest_start_addr;
  logic [8:0]  ucfg_byte_count;
  logic [15:0] ucfg_db_info;
  logic        ucfg_wr_n, ucfg_normal_trigger, ucfg_db_trigger;
  logic        srio_initial_busy = 1'b0, srio_db_resp = 1'b0;
  logic        dma_busy, dma_done, dma_err;
  logic [1:0]  dma_err_code;

  srio_dma_scheduler #(.MAX_PKT_BYTES(256), .DB_TIMEOUT(TMO)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .dma_start(dma_start), .dma_abort(dma_abort),
    .dma_src_addr(dma_src_addr), .dma_dest_addr(dma_dest_addr),
    .dma_total_bytes(dma_total_bytes), .dma_dest_id(dma_dest_id), .dma_db_en(dma_db_en),
    .dma_db_info(dma_db_info), .ucfg_dest_id(ucfg_dest_id),
    .ucfg_src_start_addr(ucfg_src_start_addr), .ucfg_dest_start_addr(ucfg_dest_start_addr),
    .ucfg_byte_count(ucfg_byte_count), .ucfg_db_info(ucfg_db_info), .ucfg_wr_n(ucfg_wr_n),
    .ucfg_normal_trigger(ucfg_normal_trigger), .ucfg_db_trigger(ucfg_db_trigger),
    .srio_initial_busy(srio_initial_busy), .srio_db_resp(srio_db_resp),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err), .dma_err_code(dma_err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Initiator model: busy for a few cycles after each request; optional doorbell reply.
  bit hold_busy = 0, resp_en = 0;
  int bcnt = 0, rcnt = -1;
  always @(negedge clk) begin
    srio_db_resp = 1'b0;
    if (ucfg_normal_trigger || ucfg_db_trigger) begin
      bcnt = BL;
      srio_initial_busy = 1'b1;
    end else if (bcnt > 0) begin
      bcnt = bcnt - 1;
      srio_initial_busy = 1'b1;
    end else begin
      srio_initial_busy = hold_busy;
    end
    if (ucfg_db_trigger && resp_en) rcnt = 10;
    else if (rcnt > 0) begin
      rcnt = rcnt - 1;
      if (rcnt == 0) begin
        srio_db_resp = 1'b1;
        rcnt = -1;
      end
    end
  end

  // Monitor of everything the DUT emits.
  logic [8:0]  q_bc[$];
  logic [31:0] q_src[$];
  logic [33:0] q_dest[$];
  int n_trig = 0, n_db = 0, n_done = 0, n_err = 0, n_both = 0;
  int last_trig_cyc = 0, db_cyc = 0, done_cyc = 0;
  logic [1:0] last_code = 2'd0;
  always @(negedge clk) begin
    if (ucfg_normal_trigger) begin
      q_bc.push_back(ucfg_byte_count);
      q_src.push_back(ucfg_src_start_addr);
      q_dest.push_back(ucfg_dest_start_addr);
      n_trig = n_trig + 1;
      last_trig_cyc = cyc;
    end
    if (ucfg_db_trigger) begin
      n_db = n_db + 1;
      db_cyc = cyc;
    end
    if (ucfg_normal_trigger && ucfg_db_trigger) n_both = n_both + 1;
    if (dma_done) begin
      n_done = n_done + 1;
      done_cyc = cyc;
    end
    if (dma_err) begin
      n_err = n_err + 1;
      last_code = dma_err_code;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    q_bc.delete(); q_src.delete(); q_dest.delete();
    n_trig = 0; n_db = 0; n_done = 0; n_err = 0; last_code = 2'd0;
  endtask

  task automatic job(input logic [31:0] s, input logic [33:0] d, input logic [23:0] t,
                     input logic db);
    clear_mon();
    tick(1);
    dma_src_addr = s; dma_dest_addr = d; dma_total_bytes = t; dma_db_en = db;
    dma_start = 1'b1;
    tick(1);
    dma_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (n_done == 0 && n < maxc) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_in_time"}, 64'(n < maxc), 64'd1);
    tick(2);
  endtask

  initial begin
    tick(3);
    chk("rst_busy", 64'(dma_busy), 64'd0);
    chk("rst_trig", 64'({ucfg_normal_trigger, ucfg_db_trigger}), 64'd0);
    chk("rst_bc", 64'(ucfg_byte_count), 64'd0);
    chk("rst_src", 64'(ucfg_src_start_addr), 64'd0);
    chk("rst_done_err", 64'({dma_done, dma_err, dma_err_code}), 64'd0);
    chk("rst_wr_n", 64'(ucfg_wr_n), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // 1024 bytes in four full packets, no doorbell
    job(32'h1000, 34'h2_0000_0000, 24'd1024, 1'b0);
    chk("t1_busy", 64'(dma_busy), 64'd1);
    wait_done("t1", 200);
    chk("t1_ntrig", 64'(n_trig), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_bc", 64'(q_bc[k]), 64'h100);
      chk("t1_src", 64'(q_src[k]), 64'h1000 + 64'(k) * 64'h100);
      chk("t1_dest", 64'(q_dest[k]), 64'h2_0000_0000 + 64'(k) * 64'h100);
    end
    chk("t1_ndone", 64'(n_done), 64'd1);
    chk("t1_nerr", 64'(n_err), 64'd0);
    chk("t1_ndb", 64'(n_db), 64'd0);
    chk("t1_busy_end", 64'(dma_busy), 64'd0);
    chk("t1_dest_id", 64'(ucfg_dest_id), 64'h5A);

    // 300 bytes plus doorbell answered after 10 cycles
    resp_en = 1;
    job(32'h0, 34'h100, 24'd300, 1'b1);
    wait_done("t2", 200);
    chk("t2_ntrig", 64'(n_trig), 64'd2);
    chk("t2_bc0", 64'(q_bc[0]), 64'h100);
    chk("t2_bc1", 64'(q_bc[1]), 64'h02C);
    chk("t2_src1", 64'(q_src[1]), 64'h100);
    chk("t2_ndb", 64'(n_db), 64'd1);
    chk("t2_db_after_busy", 64'((db_cyc - last_trig_cyc) > BL), 64'd1);
    chk("t2_db_info", 64'(ucfg_db_info), 64'hBEEF);
    chk("t2_ndone", 64'(n_done), 64'd1);
    chk("t2_nerr", 64'(n_err), 64'd0);
    resp_en = 0;

    // destination wraps past 2^34
    job(32'h8, 34'h3_FFFF_FF00, 24'd512, 1'b0);
    wait_done("t3", 200);
    chk("t3_ntrig", 64'(n_trig), 64'd2);
    chk("t3_dest0", 64'(q_dest[0]), 64'h3_FFFF_FF00);
    chk("t3_dest1", 64'(q_dest[1]), 64'h0);
    chk("t3_src1", 64'(q_src[1]), 64'h108);
    chk("t3_nerr", 64'(n_err), 64'd0);

    // misaligned source, misaligned dest and zero length are rejected
    job(32'h1004, 34'h0, 24'd64, 1'b0);
    chk("t4_err", 64'(dma_err), 64'd1);
    chk("t4_code", 64'(dma_err_code), 64'd1);
    chk("t4_busy", 64'(dma_busy), 64'd0);
    tick(10);
    chk("t4_ntrig", 64'(n_trig), 64'd0);
    chk("t4_ndone", 64'(n_done), 64'd0);
    job(32'h0, 34'h3, 24'd64, 1'b0);
    chk("t4_dest_err", 64'({dma_err, dma_err_code}), 64'b101);
    job(32'h0, 34'h0, 24'd0, 1'b0);
    chk("t4_zero_err", 64'({dma_err, dma_err_code}), 64'b101);
    tick(5);
    chk("t4_zero_ntrig", 64'(n_trig), 64'd0);

    // abort during packet 2
    job(32'h0, 34'h0, 24'd1024, 1'b0);
    for (int n = 0; n < 100 && n_trig < 2; n++) tick(1);
    dma_abort = 1'b1;
    wait_done("t5", 200);
    dma_abort = 1'b0;
    chk("t5_ntrig", 64'(n_trig), 64'd2);
    chk("t5_nerr", 64'(n_err), 64'd1);
    chk("t5_code", 64'(last_code), 64'd2);

    // doorbell never answered
    job(32'h0, 34'h0, 24'd8, 1'b1);
    wait_done("t6", TMO + 100);
    chk("t6_bc", 64'(q_bc[0]), 64'd8);
    chk("t6_ndb", 64'(n_db), 64'd1);
    chk("t6_code", 64'(last_code), 64'd3);
    chk("t6_ndone", 64'(n_done), 64'd1);
    chk("t6_latency", 64'((done_cyc - db_cyc) >= TMO && (done_cyc - db_cyc) <= TMO + 2), 64'd1);

    // initiator held busy, then reset in the middle of PKT_WAIT
    hold_busy = 1;
    job(32'h40, 34'h80, 24'd16, 1'b0);
    tick(100);
    chk("t7_no_trig", 64'(n_trig), 64'd0);
    chk("t7_busy", 64'(dma_busy), 64'd1);
    chk("t7_bc", 64'(ucfg_byte_count), 64'd16);
    hold_busy = 0;
    for (int n = 0; n < 20 && n_trig < 1; n++) tick(1);
    chk("t7_trig", 64'(n_trig), 64'd1);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", 64'(dma_busy), 64'd0);
    chk("t7_rst_addr", 64'({ucfg_src_start_addr, ucfg_byte_count}), 64'd0);
    chk("t7_rst_trig", 64'({ucfg_normal_trigger, ucfg_db_trigger}), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    chk("t7_no_done", 64'(n_done), 64'd0);
    job(32'h0, 34'h0, 24'd256, 1'b0);
    wait_done("t8", 200);
    chk("t8_ntrig", 64'(n_trig), 64'd1);
    chk("t8_ndone", 64'(n_done), 64'd1);
    chk("t8_nerr", 64'(n_err), 64'd0);

    chk("never_both_triggers", 64'(n_both), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
